// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : shift_add_mult_pkg

// File: rtl/shift_add_mult_n_twos_abs.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes and to restore the sign of the finished product.
module twos_abs #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic         neg,
   output logic [W-1:0] y
);

   // Negate when requested; the most negative value maps onto itself,
   // which read as unsigned is exactly its magnitude.
   always_comb begin
      y = neg ? (~a + W'(1)) : a;
   end

endmodule : twos_abs

// File: rtl/shift_add_mult_n.sv
// Sequential shift-and-add multiplier: one multiplier bit per CALC cycle,
// sign restored in FIX, one-cycle d_end pulse in DONE.
module shift_add_mult_n
   import shift_add_mult_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int SIGNED_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   q,
   output logic [2*WIDTH-1:0] result,
   output logic               busy,
   output logic               d_end
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;        // upper half: partial sum, lower half: multiplier
   logic [2*WIDTH-1:0] acc_shift;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH:0]     add_sum;    // carry in the top bit
   logic               prod_neg;
   logic               eff_signed;
   logic               last_bit;

   assign eff_signed = (SIGNED_EN != 0) && signed_mode;

   twos_abs #(.W(WIDTH)) u_abs_b (
      .a   (b),
      .neg (eff_signed & b[WIDTH-1]),
      .y   (b_mag)
   );

   twos_abs #(.W(WIDTH)) u_abs_q (
      .a   (q),
      .neg (eff_signed & q[WIDTH-1]),
      .y   (q_mag)
   );

   twos_abs #(.W(2 * WIDTH)) u_fix (
      .a   (acc),
      .neg (prod_neg),
      .y   (prod_fix)
   );

   // One add-and-shift step: conditional add into the upper half, then the
   // carry, sum and remaining multiplier bits move right by one.
   always_comb begin
      add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      if (acc[0]) begin
         add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
      end
      acc_shift = {add_sum, acc[WIDTH-1:1]};
      last_bit  = (cnt == CNT_W'(WIDTH - 1));
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and status decode.
   // NOTE: every output gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      d_end     = (state == DONE);
      case (state)
         IDLE:    if (start)    state_nxt = CALC;
         CALC:    if (last_bit) state_nxt = FIX;
         FIX:                   state_nxt = DONE;
         DONE:                  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // Datapath: capture operands, iterate, then load the signed product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         b_reg    <= '0;
         prod_neg <= 1'b0;
         cnt      <= '0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc      <= {{WIDTH{1'b0}}, q_mag};
                  b_reg    <= b_mag;
                  prod_neg <= eff_signed & (b[WIDTH-1] ^ q[WIDTH-1]);
                  cnt      <= '0;
               end
            end
            CALC: begin
               acc <= acc_shift;
               cnt <= cnt + CNT_W'(1);
            end
            FIX:     result <= prod_fix;
            default: ;
         endcase
      end
   end

endmodule : shift_add_mult_n

// File: tb/tb_shift_add_mult_n.sv
// Directed self-checking bench for shift_add_mult_n at WIDTH=8.
module tb_shift_add_mult_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [7:0]  b = '0;
   logic [7:0]  q = '0;
   logic [15:0] result;
   logic        busy;
   logic        d_end;

   logic        start_u = 1'b0;
   logic        mode_u = 1'b0;
   logic [7:0]  b_u = '0;
   logic [7:0]  q_u = '0;
   logic [15:0] result_u;
   logic        busy_u;
   logic        d_end_u;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   shift_add_mult_n #(.WIDTH(8), .SIGNED_EN(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_mode (signed_mode),
      .b           (b),
      .q           (q),
      .result      (result),
      .busy        (busy),
      .d_end       (d_end)
   );

   shift_add_mult_n #(.WIDTH(8), .SIGNED_EN(0)) dut_u (
      .clk         (clk),
      .rst         (rst),
      .start       (start_u),
      .signed_mode (mode_u),
      .b           (b_u),
      .q           (q_u),
      .result      (result_u),
      .busy        (busy_u),
      .d_end       (d_end_u)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Present one start cycle, then count cycles (from the cycle that
   // presented start) until d_end is seen, bounded.
   task automatic do_op(input logic sm, input logic [7:0] bv, input logic [7:0] qv,
                        output int lat);
      @(negedge clk);
      signed_mode = sm; b = bv; q = qv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!d_end && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int   lat;
      int   n;
      logic busy_drop;
      logic saw_dend;

      // Reset state
      #1;
      check("rst_busy",   busy,   0);
      check("rst_d_end",  d_end,  0);
      check("rst_result", result, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Unsigned 127 x 201, latency 10
      do_op(1'b0, 8'd127, 8'd201, lat);
      check("u127x201_lat", lat,    10);
      check("u127x201",     result, 25527);
      @(negedge clk);
      check("d_end_one_cycle", d_end, 0);
      check("idle_busy",       busy,  0);
      repeat (3) @(negedge clk);
      check("result_hold", result, 25527);

      do_op(1'b0, 8'd255, 8'd255, lat);
      check("u255x255", result, 65025);
      do_op(1'b0, 8'd0, 8'd0, lat);
      check("u0x0", result, 0);
      do_op(1'b0, 8'd128, 8'd2, lat);
      check("u128x2", result, 256);

      // Signed corners
      do_op(1'b1, 8'hFF, 8'hFF, lat);
      check("s_m1xm1", result, 16'h0001);
      do_op(1'b1, 8'h80, 8'h80, lat);
      check("s_minxmin", result, 16'h4000);
      check("s_lat", lat, 10);
      do_op(1'b1, 8'h80, 8'h7F, lat);
      check("s_minxmax", result, 16'hC080);
      do_op(1'b1, 8'h00, 8'hFF, lat);
      check("s_0xm1", result, 16'h0000);
      do_op(1'b1, 8'h05, 8'hFD, lat);
      check("s_5xm3", result, 16'hFFF1);

      // Start re-pulsed during CALC with other operands is ignored
      @(negedge clk);
      signed_mode = 1'b0; b = 8'd127; q = 8'd201; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      busy_drop = 1'b0;
      while (!d_end && n < 40) begin
         if (!busy) busy_drop = 1'b1;
         if (n == 3) begin
            start = 1'b1; b = 8'd5; q = 8'd9;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      check("repulse_lat",    n,         10);
      check("repulse_result", result,    25527);
      check("repulse_busy",   busy_drop, 0);
      repeat (3) @(negedge clk);
      check("repulse_no_restart", busy, 0);

      // Reset at CALC cycle 4 aborts; next op is normal
      @(negedge clk);
      signed_mode = 1'b0; b = 8'd200; q = 8'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy",   busy,   0);
      check("midrst_result", result, 0);
      @(negedge clk);
      rst = 1'b0;
      saw_dend = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (d_end) saw_dend = 1'b1;
      end
      check("midrst_no_d_end", saw_dend, 0);
      check("midrst_result_0", result,   0);
      do_op(1'b0, 8'd10, 8'd30, lat);
      check("post_rst_10x30", result, 300);
      check("post_rst_lat",   lat,    10);

      // Start held high: back-to-back spacing of WIDTH+3
      @(negedge clk);
      signed_mode = 1'b0; b = 8'd3; q = 8'd7; start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         b = 8'd4; q = 8'd5;
      end while (!d_end && n < 40);
      check("b2b_first", result, 21);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d_end && n < 40);
      start = 1'b0;
      check("b2b_period", n,      11);
      check("b2b_second", result, 20);

      // SIGNED_EN=0 build ignores signed_mode
      @(negedge clk);
      mode_u = 1'b1; b_u = 8'hFF; q_u = 8'h02; start_u = 1'b1;
      @(negedge clk);
      start_u = 1'b0;
      n = 1;
      while (!d_end_u && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("unsigned_build_lat", n,        10);
      check("unsigned_build",     result_u, 510);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_shift_add_mult_n
